// File: rtl/priority_encoder.sv
// priority_encoder: registered most-significant-bit priority encoder.
// The combinational core is a halving tree stored as an implicit binary heap.
// Node 1 is the root. Node n has children 2n (low half) and 2n+1 (high half).
// Nodes WIDTH/2 .. WIDTH-1 are leaves, and each leaf encodes one bit pair of a.
// The result is captured into an output register that has one cycle of latency.
module priority_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  output logic [IDX_W-1:0] y,
  output logic             none
);

  localparam int HALF = WIDTH / 2;

  // Every heap node carries a full-width index.
  // A node at depth d covers WIDTH>>d bits, so only its low IDX_W-d index
  // bits can be non-zero. Its upper bits are always driven to zero.
  logic [IDX_W-1:0] idx_h [1:WIDTH-1];
  logic             nz_h  [1:WIDTH-1];

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_node
      // Depth of this node in the tree: floor(log2(gi)).
      localparam int DEPTH = $clog2(gi + 1) - 1;
      // Number of index bits produced by each child of this node.
      localparam int CW    = IDX_W - DEPTH - 1;

      if (gi >= HALF) begin : g_leaf
        // Leaf: encode the bit pair {a[2j+1], a[2j]}, where j = gi - HALF.
        localparam int J = gi - HALF;
        assign idx_h[gi] = {{(IDX_W-1){1'b0}}, a[2*J+1]};
        assign nz_h[gi]  = ~(a[2*J+1] | a[2*J]);
      end else begin : g_inner
        // Inner node: the high half wins whenever it holds any set bit.
        // The selected half is flagged by setting index bit CW.
        localparam logic [IDX_W-1:0] HI_BIT = IDX_W'(1) << CW;
        assign idx_h[gi] = nz_h[2*gi+1] ? idx_h[2*gi]
                                        : (idx_h[2*gi+1] | HI_BIT);
        assign nz_h[gi]  = nz_h[2*gi+1] & nz_h[2*gi];
      end
    end
  endgenerate

  logic [IDX_W-1:0] enc_idx;
  logic             enc_nz;

  assign enc_idx = idx_h[1];
  assign enc_nz  = nz_h[1];

  logic [IDX_W-1:0] y_q, y_d;
  logic             none_q, none_d;
  logic             out_valid_q, out_valid_d;

  // Next-state: capture the encoder result on valid; otherwise hold y/none.
  // When the input is not valid, a is never observed, so X/Z on a is harmless.
  always_comb begin
    y_d         = y_q;
    none_d      = none_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      y_d         = enc_idx;
      none_d      = enc_nz;
      out_valid_d = 1'b1;
    end
  end

  // Output register with synchronous active-low reset; reset overrides capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q         <= '0;
      none_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      none_q      <= none_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign none      = none_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_priority_encoder.sv
// tb_priority_encoder: random and directed stimulus for the MSB priority encoder.
// A behavioural model is checked on every cycle. Literal per-step expectations
// pin down the model itself.
module tb_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic       out_valid;
  logic [2:0] y;
  logic       none;

  int total = 0;
  int bad   = 0;

  priority_encoder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .out_valid (out_valid),
    .y         (y),
    .none      (none)
  );

  always #5 clk = ~clk;

  // Position of the highest set bit, found by a plain scan from bit 0 upward.
  function automatic int msb_pos(input logic [7:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++)
      if (v[i]) r = i;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: what the outputs must show after each edge.
  int m_valid, m_y, m_none;
  bit m_live = 1'b0;

  // Model: interprets the sampled inputs on every rising edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 0;
      m_y     <= 0;
      m_none  <= 1;
    end else if (in_valid) begin
      m_valid <= 1;
      m_y     <= msb_pos(a);
      m_none  <= (a == 8'h00) ? 1 : 0;
    end else begin
      m_valid <= 0;
    end
    m_live <= 1'b1;
  end

  // Compare process: every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("mdl_out_valid", int'(out_valid), m_valid);
      chk("mdl_y",         int'(y),         m_y);
      chk("mdl_none",      int'(none),      m_none);
    end
  end

  // Drive one cycle of inputs, then check literal expectations just after the edge.
  task automatic step(input string name, input logic r, input logic v,
                      input logic [7:0] d, input int ev, input int ey, input int en);
    @(negedge clk);
    rst_n    = r;
    in_valid = v;
    a        = d;
    @(posedge clk);
    #1;
    chk({name, "_out_valid"}, int'(out_valid), ev);
    chk({name, "_y"},         int'(y),         ey);
    chk({name, "_none"},      int'(none),      en);
    $display("txn %s rst_n=%0b in_valid=%0b a=%02h -> out_valid=%0b y=%0d none=%0b",
             name, r, v, d, out_valid, y, none);
  endtask

  initial begin
    int s;
    logic [7:0] b;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 8'hFF;

    // Reset takes priority over a valid input.
    step("rst0", 1'b0, 1'b1, 8'hFF, 0, 0, 1);
    step("rst1", 1'b0, 1'b1, 8'hFF, 0, 0, 1);
    step("post_rst", 1'b1, 1'b0, 8'hFF, 0, 0, 1);

    // Single-bit inputs.
    for (int k = 0; k < 8; k++)
      step($sformatf("bit%0d", k), 1'b1, 1'b1, 8'(1 << k), 1, k, 0);

    // Lower set bits are ignored.
    step("mask_b6", 1'b1, 1'b1, 8'b1011_0110, 1, 7, 0);
    step("mask_1f", 1'b1, 1'b1, 8'b0001_1111, 1, 4, 0);
    step("mask_03", 1'b1, 1'b1, 8'b0000_0011, 1, 1, 0);

    // All-zero input versus bit 0 only: same y, different none.
    step("zero", 1'b1, 1'b1, 8'h00, 1, 0, 1);
    step("one",  1'b1, 1'b1, 8'h01, 1, 0, 0);

    // Back-to-back random stream with a controlled MSB position.
    for (int i = 0; i < 256; i++) begin
      s = int'($urandom_range(0, 8));
      b = 8'($urandom) | 8'h80;
      if (s == 8)
        step($sformatf("rnd%0d", i), 1'b1, 1'b1, b >> s, 1, 0, 1);
      else
        step($sformatf("rnd%0d", i), 1'b1, 1'b1, b >> s, 1, 7 - s, 0);
    end

    // Hold across gap cycles while a changes.
    step("hold_cap", 1'b1, 1'b1, 8'h40, 1, 6, 0);
    for (int g = 0; g < 3; g++)
      step($sformatf("gap%0d", g), 1'b1, 1'b0, 8'h01, 0, 6, 0);

    // Reset in mid-run returns the outputs to their idle values.
    step("rst_mid", 1'b0, 1'b1, 8'h80, 0, 0, 1);
    step("after_mid", 1'b1, 1'b1, 8'h80, 1, 7, 0);

    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
